// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline stall control for load-use hazards and the iterative divider.
// Latency: stall, div_start and div_cancel are combinational; counters update one edge later.
// Backpressure: the divider stall (PC..EX) beats load-use (PC..ID); flush and reset clear all stalls.
module hazard_stall_ctrl #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               ex_load,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_div_req,
  input  logic               ex_div_signed,
  input  logic               div_ready,
  output logic               div_start,
  output logic               div_signed,
  output logic               div_cancel,
  output logic [STALL_W-1:0] stall,
  output logic [CNT_W-1:0]   load_use_cnt,
  output logic [CNT_W-1:0]   div_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Stall masks: divider holds PC, IF, ID and EX; load-use holds PC, IF, ID so EX takes a bubble.
  localparam logic [STALL_W-1:0] STALL_DIV = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] STALL_LU  = STALL_W'(3'b111);

  state_t           r_state;
  logic             r_div_signed;
  logic [CNT_W-1:0] r_load_use_cnt;
  logic [CNT_W-1:0] r_div_stall_cnt;

  logic w_active;
  logic w_start;
  logic w_busy;
  logic w_lu_hit;
  logic w_div_stall;
  logic w_lu_stall;

  // Reset gates every combinational output so inputs are ignored while resetn is low.
  assign w_active = resetn & ~flush;
  assign w_start  = w_active & (r_state == S_IDLE) & ex_div_req;
  assign w_busy   = w_active & (r_state == S_BUSY);

  // Load-use: EX holds a load whose destination (never $0) is read by the instruction in ID.
  assign w_lu_hit = id_valid & ex_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
                    ((id_rs_used & (id_rs == ex_rf_waddr)) |
                     (id_rt_used & (id_rt == ex_rf_waddr)));

  assign w_div_stall = w_start | w_busy;
  assign w_lu_stall  = w_active & w_lu_hit & ~w_div_stall;

  // Stall bus: divider first, then load-use, otherwise free-running.
  always_comb begin
    stall = '0;
    if (w_div_stall) begin
      stall = STALL_DIV;
    end else if (w_lu_stall) begin
      stall = STALL_LU;
    end
  end

  assign div_start  = w_start;
  // Signedness passes straight through on the start cycle, then is held from the register.
  assign div_signed = w_start ? ex_div_signed : r_div_signed;
  assign div_cancel = resetn & flush & (r_state == S_BUSY);

  assign load_use_cnt  = r_load_use_cnt;
  assign div_stall_cnt = r_div_stall_cnt;

  // Divider FSM; flush wins over div_ready and over a new request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_div_signed <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_div_req) begin
            r_state      <= S_BUSY;
            r_div_signed <= ex_div_signed;
          end
        end
        S_BUSY: begin
          if (div_ready) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating stall-cycle counters; flush cycles never count because the stalls are gated off.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_load_use_cnt  <= '0;
      r_div_stall_cnt <= '0;
    end else begin
      if (w_lu_stall && (r_load_use_cnt != '1)) begin
        r_load_use_cnt <= r_load_use_cnt + 1'b1;
      end
      if (w_div_stall && (r_div_stall_cnt != '1)) begin
        r_div_stall_cnt <= r_div_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: inputs change on the falling edge, outputs are
// checked shortly after, counters are checked one falling edge after the counted cycle.
// Counters are built 6 bits wide so saturation is reachable in a short run.
module tb_hazard_stall_ctrl;

  localparam int STALL_W = 6;
  localparam int CNT_W   = 6;

  logic               clk;
  logic               resetn;
  logic               flush;
  logic               id_valid;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               ex_load;
  logic               ex_rf_we;
  logic [4:0]         ex_rf_waddr;
  logic               ex_div_req;
  logic               ex_div_signed;
  logic               div_ready;
  logic               div_start;
  logic               div_signed;
  logic               div_cancel;
  logic [STALL_W-1:0] stall;
  logic [CNT_W-1:0]   load_use_cnt;
  logic [CNT_W-1:0]   div_stall_cnt;

  int n_checks;
  int n_errors;

  hazard_stall_ctrl #(.STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .ex_load       (ex_load),
    .ex_rf_we      (ex_rf_we),
    .ex_rf_waddr   (ex_rf_waddr),
    .ex_div_req    (ex_div_req),
    .ex_div_signed (ex_div_signed),
    .div_ready     (div_ready),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_cancel    (div_cancel),
    .stall         (stall),
    .load_use_cnt  (load_use_cnt),
    .div_stall_cnt (div_stall_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    flush         = 1'b0;
    id_valid      = 1'b0;
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    id_rs_used    = 1'b0;
    id_rt_used    = 1'b0;
    ex_load       = 1'b0;
    ex_rf_we      = 1'b0;
    ex_rf_waddr   = 5'd0;
    ex_div_req    = 1'b0;
    ex_div_signed = 1'b0;
    div_ready     = 1'b0;
  endtask

  // Load in EX writing r<waddr>, ID reading r<rs> through rs.
  task automatic set_lu(input logic [4:0] waddr, input logic [4:0] rs);
    id_valid    = 1'b1;
    id_rs       = rs;
    id_rs_used  = 1'b1;
    ex_load     = 1'b1;
    ex_rf_we    = 1'b1;
    ex_rf_waddr = waddr;
  endtask

  task automatic clr_lu();
    id_valid    = 1'b0;
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_rs_used  = 1'b0;
    id_rt_used  = 1'b0;
    ex_load     = 1'b0;
    ex_rf_we    = 1'b0;
    ex_rf_waddr = 5'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset held with every request active: outputs must stay quiet.
    clr_inputs();
    resetn        = 1'b0;
    ex_div_req    = 1'b1;
    ex_div_signed = 1'b1;
    set_lu(5'd5, 5'd5);
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_div_start", 32'(div_start), 32'h0);
    chk("rst_div_cancel", 32'(div_cancel), 32'h0);
    chk("rst_div_signed", 32'(div_signed), 32'h0);
    chk("rst_lu_cnt", 32'(load_use_cnt), 32'h0);
    chk("rst_div_cnt", 32'(div_stall_cnt), 32'h0);
    @(negedge clk); #1;
    chk("rst_stall_edge", 32'(stall), 32'h0);
    chk("rst_div_cnt_edge", 32'(div_stall_cnt), 32'h0);

    @(negedge clk);
    clr_inputs();
    resetn = 1'b1;
    #1 chk("idle_stall", 32'(stall), 32'h0);

    // Load-use via rs: one stall cycle, one count.
    @(negedge clk);
    set_lu(5'd5, 5'd5);
    #1 chk("lu_rs_stall", 32'(stall), 32'h07);
    chk("lu_rs_no_start", 32'(div_start), 32'h0);
    @(negedge clk);
    clr_lu();
    #1 chk("lu_rs_release", 32'(stall), 32'h0);
    chk("lu_cnt_1", 32'(load_use_cnt), 32'h1);

    // Writes to $0 never create a hazard.
    @(negedge clk);
    set_lu(5'd0, 5'd0);
    #1 chk("lu_zero_stall", 32'(stall), 32'h0);
    @(negedge clk);
    clr_lu();
    #1 chk("lu_zero_cnt", 32'(load_use_cnt), 32'h1);

    // rt path and the qualifying terms, all within one low phase; the final hit counts.
    @(negedge clk);
    set_lu(5'd7, 5'd3);
    id_rt = 5'd7;
    #1 chk("lu_rt_unused", 32'(stall), 32'h0);
    id_rt_used = 1'b1;
    #1 chk("lu_rt_stall", 32'(stall), 32'h07);
    id_valid = 1'b0;
    #1 chk("lu_id_invalid", 32'(stall), 32'h0);
    id_valid = 1'b1;
    ex_load  = 1'b0;
    #1 chk("lu_not_load", 32'(stall), 32'h0);
    ex_load  = 1'b1;
    ex_rf_we = 1'b0;
    #1 chk("lu_no_we", 32'(stall), 32'h0);
    ex_rf_we = 1'b1;
    #1 chk("lu_rt_final", 32'(stall), 32'h07);
    @(negedge clk);
    clr_lu();
    #1 chk("lu_cnt_2", 32'(load_use_cnt), 32'h2);

    // Signed division: start + 32 BUSY cycles (div_ready on the 32nd) = 33 stall cycles.
    @(negedge clk);
    ex_div_req    = 1'b1;
    ex_div_signed = 1'b1;
    #1 chk("div_start_stall", 32'(stall), 32'h0F);
    chk("div_start_pulse", 32'(div_start), 32'h1);
    chk("div_start_signed", 32'(div_signed), 32'h1);
    chk("div_start_cancel", 32'(div_cancel), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      ex_div_signed = 1'b0;
      div_ready     = (k == 32);
      #1 chk("div_busy_stall", 32'(stall), 32'h0F);
      chk("div_busy_start", 32'(div_start), 32'h0);
      chk("div_busy_signed", 32'(div_signed), 32'h1);
    end
    // DONE: no stall, request and div_ready both ignored.
    @(negedge clk);
    div_ready = 1'b1;
    #1 chk("div_done_stall", 32'(stall), 32'h0);
    chk("div_done_start", 32'(div_start), 32'h0);
    @(negedge clk);
    ex_div_req = 1'b0;
    #1 chk("div_idle_stall", 32'(stall), 32'h0);
    chk("div_cnt_33", 32'(div_stall_cnt), 32'd33);
    @(negedge clk);
    div_ready = 1'b0;
    #1 chk("div_ready_idle_ignored", 32'(stall), 32'h0);

    // Division and load-use together: divider mask wins, only the divider counter moves.
    @(negedge clk);
    ex_div_req    = 1'b1;
    ex_div_signed = 1'b0;
    set_lu(5'd9, 5'd9);
    #1 chk("both_stall", 32'(stall), 32'h0F);
    chk("both_start", 32'(div_start), 32'h1);
    chk("both_signed", 32'(div_signed), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      clr_lu();
      #1 chk("both_busy_stall", 32'(stall), 32'h0F);
    end
    // BUSY cycle 10: flush with div_ready in the same cycle.
    @(negedge clk);
    flush     = 1'b1;
    div_ready = 1'b1;
    #1 chk("flush_busy_stall", 32'(stall), 32'h0);
    chk("flush_busy_cancel", 32'(div_cancel), 32'h1);
    chk("flush_busy_start", 32'(div_start), 32'h0);
    chk("both_lu_cnt", 32'(load_use_cnt), 32'h2);
    chk("flush_div_cnt_43", 32'(div_stall_cnt), 32'd43);
    // Back in IDLE (not DONE): the held request starts a new division at once.
    @(negedge clk);
    flush         = 1'b0;
    div_ready     = 1'b0;
    ex_div_signed = 1'b1;
    #1 chk("after_flush_start", 32'(div_start), 32'h1);
    chk("after_flush_cancel", 32'(div_cancel), 32'h0);
    chk("after_flush_stall", 32'(stall), 32'h0F);
    chk("after_flush_signed", 32'(div_signed), 32'h1);
    chk("after_flush_cnt", 32'(div_stall_cnt), 32'd43);

    // Reset on BUSY cycle 5.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ex_div_signed = 1'b0;
      #1 chk("pre_rst_busy_stall", 32'(stall), 32'h0F);
    end
    @(negedge clk);
    #1 chk("pre_rst_div_cnt_48", 32'(div_stall_cnt), 32'd48);
    resetn = 1'b0;
    #1 chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_cancel", 32'(div_cancel), 32'h0);
    chk("mid_rst_div_cnt", 32'(div_stall_cnt), 32'h0);
    chk("mid_rst_lu_cnt", 32'(load_use_cnt), 32'h0);
    chk("mid_rst_signed", 32'(div_signed), 32'h0);
    @(negedge clk);
    #1 chk("mid_rst_hold_stall", 32'(stall), 32'h0);
    @(negedge clk);
    resetn     = 1'b1;
    ex_div_req = 1'b0;
    #1 chk("rst_release_stall", 32'(stall), 32'h0);
    @(negedge clk);
    ex_div_req = 1'b1;
    #1 chk("restart_start", 32'(div_start), 32'h1);
    chk("restart_stall", 32'(stall), 32'h0F);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      div_ready = (k == 3);
      #1 chk("restart_busy_stall", 32'(stall), 32'h0F);
    end
    @(negedge clk);
    div_ready = 1'b0;
    #1 chk("restart_done_stall", 32'(stall), 32'h0);
    @(negedge clk);
    ex_div_req = 1'b0;
    #1 chk("restart_div_cnt_4", 32'(div_stall_cnt), 32'd4);

    // Flush on the IDLE start cycle suppresses the start; flush on BUSY cycle 1 cancels.
    @(negedge clk);
    ex_div_req = 1'b1;
    flush      = 1'b1;
    #1 chk("flush_idle_start", 32'(div_start), 32'h0);
    chk("flush_idle_stall", 32'(stall), 32'h0);
    chk("flush_idle_cancel", 32'(div_cancel), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_idle_then_start", 32'(div_start), 32'h1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_busy1_cancel", 32'(div_cancel), 32'h1);
    @(negedge clk);
    flush      = 1'b0;
    ex_div_req = 1'b0;
    #1 chk("flush_busy1_cnt_5", 32'(div_stall_cnt), 32'd5);
    chk("flush_busy1_cancel_off", 32'(div_cancel), 32'h0);

    // Load-use under flush is neither stalled nor counted.
    @(negedge clk);
    set_lu(5'd12, 5'd12);
    flush = 1'b1;
    #1 chk("lu_flush_stall", 32'(stall), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    clr_lu();
    #1 chk("lu_flush_cnt", 32'(load_use_cnt), 32'h0);

    // Saturation: 70 load-use cycles on a 6-bit counter stop at 63.
    @(negedge clk);
    set_lu(5'd12, 5'd12);
    for (int k = 0; k < 70; k++) @(negedge clk);
    clr_lu();
    #1 chk("lu_cnt_sat", 32'(load_use_cnt), 32'd63);

    // Saturation: a 70-cycle division takes div_stall_cnt from 5 to the ceiling.
    @(negedge clk);
    ex_div_req = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      div_ready = (k == 70);
    end
    @(negedge clk);
    div_ready = 1'b0;
    #1 chk("sat_done_stall", 32'(stall), 32'h0);
    @(negedge clk);
    ex_div_req = 1'b0;
    #1 chk("div_cnt_sat", 32'(div_stall_cnt), 32'd63);
    chk("lu_cnt_sat_hold", 32'(load_use_cnt), 32'd63);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL provide parameter STALL_W, default 6, width of the stall bus; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB, 1 = Stop.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the saturating performance counters.
REQ-003 SHALL provide port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL provide port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port flush, input, 1, exception/redirect flush of the whole pipeline.
REQ-006 SHALL provide ports id_valid (input, 1), id_rs (input, 5), id_rt (input, 5), id_rs_used (input, 1) and id_rt_used (input, 1), describing the instruction in ID and its register reads.
REQ-007 SHALL provide ports ex_load (input, 1), ex_rf_we (input, 1) and ex_rf_waddr (input, 5), describing the instruction in EX.
REQ-008 SHALL provide ports ex_div_req (input, 1) and ex_div_signed (input, 1): EX holds div/divu.
REQ-009 SHALL provide port div_ready, input, 1, one-cycle pulse from the iterative divider when the quotient/remainder are valid.
REQ-010 SHALL provide ports div_start (output, 1), div_signed (output, 1) and div_cancel (output, 1), the divider control.
REQ-011 SHALL provide port stall, output, STALL_W, the pipeline stall bus.
REQ-012 SHALL provide ports load_use_cnt (output, CNT_W) and div_stall_cnt (output, CNT_W), stall-cycle counters.

Function
REQ-013 SHALL implement a divider FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL, in IDLE with ex_div_req=1 and flush=0, drive div_start=1 for exactly that cycle, drive div_signed=ex_div_signed, and enter BUSY.
REQ-015 SHALL hold div_signed stable from the start cycle through BUSY, registered at the start cycle.
REQ-016 SHALL, in BUSY, stay until div_ready=1, then enter DONE; div_ready in IDLE or DONE is ignored.
REQ-017 SHALL, in DONE, last exactly one cycle, ignore ex_div_req, and return to IDLE.
REQ-018 SHALL drive stall=6'b001111 combinationally in the IDLE start cycle and in every BUSY cycle, including the BUSY cycle in which div_ready arrives.
REQ-019 SHALL drive no divider stall in DONE, so the EX instruction advances on the next edge.
REQ-020 SHALL detect load-use as id_valid & ex_load & ex_rf_we & ex_rf_waddr!=0 & ((id_rs_used & id_rs==ex_rf_waddr) | (id_rt_used & id_rt==ex_rf_waddr)).
REQ-021 SHALL, on load-use, drive stall=6'b000111, so that ID inserts a bubble into EX.
REQ-022 SHALL give the divider stall priority over load-use; when both apply, stall=6'b001111.
REQ-023 SHALL drive stall=0 when no condition applies.
REQ-024 SHALL, on flush=1, force stall=0 and div_start=0 that cycle and put the FSM in IDLE on the next edge.
REQ-025 SHALL pulse div_cancel=1 for one cycle when flush=1 occurs in BUSY; div_cancel stays 0 in all other cases.
REQ-026 SHALL apply flush ahead of div_ready arriving in the same cycle: the FSM goes to IDLE, not DONE.
REQ-027 SHALL increment load_use_cnt on each edge where the load-use stall was driven, and div_stall_cnt on each edge where the divider stall was driven.
REQ-028 SHALL saturate both counters at all-ones with no wrap.
REQ-029 SHALL not increment either counter in flush cycles.
REQ-030 SHALL be stall-only: stall is a combinational function of state and inputs, with no extra cycles of delay.

Reset
REQ-031 SHALL, while resetn=0, asynchronously force state=IDLE, div_signed=0, load_use_cnt=0 and div_stall_cnt=0.
REQ-032 SHALL hold stall=0, div_start=0 and div_cancel=0 during reset, ignoring all inputs.
REQ-033 SHALL, when reset is asserted mid-BUSY, abandon the division without a div_cancel pulse; the divider is reset by the same resetn.
REQ-034 SHALL resume normal operation on the first rising edge after resetn deasserts.

Verification
REQ-035 SHALL cover load-use: ex_load=1, ex_rf_we=1, ex_rf_waddr=5, id_rs=5, id_rs_used=1 -> stall=000111 for one cycle and load_use_cnt=1.
REQ-036 SHALL cover the $0 exception: same as REQ-035 with ex_rf_waddr=0 -> stall=000000 and load_use_cnt unchanged.
REQ-037 SHALL cover a division: ex_div_req=1 and ex_div_signed=1, div_ready pulsed 32 cycles after div_start -> div_start high 1 cycle, div_signed=1, stall=001111 for 33 cycles, then 0 in DONE, and div_stall_cnt=33.
REQ-038 SHALL cover division plus load-use: ex_div_req=1 and a load-use hit in the same cycle -> stall=001111.
REQ-039 SHALL cover flush in BUSY: flush=1 on BUSY cycle 10, with div_ready also pulsed that cycle -> stall=0, div_cancel pulse, FSM IDLE next cycle, no DONE.
REQ-040 SHALL cover reset mid-BUSY: resetn low on BUSY cycle 5 -> immediately stall=0 and counters 0; after release, a new ex_div_req restarts with div_start.
